alu_8op: RTL and testbench

ALU_8OP -- requirements
Module: alu_8op

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_shifter.sv | 24 ++
 rtl/alu_8op.sv | 67 ++++++
 tb/tb_alu_8op.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the 8-operation ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_CMP = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter, logical left/right with zero fill.
// Zero latency, no flow control; stage i moves the data by 2**i when amt[i] is set.
module alu_shifter #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  input  logic             left,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stg [SHW+1];

  assign stg[0] = data;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    assign stg[i+1] = amt[i] ? (left ? (stg[i] << (2**i)) : (stg[i] >> (2**i)))
                             : stg[i];
  end

  assign result = stg[SHW];

endmodule

// File: rtl/alu_8op.sv
// 8-operation ALU with a single output register: one-cycle latency, full throughput.
// No backpressure; in_valid=0 holds Output/Zero and drops out_valid.
module alu_8op
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   Shiftamt,
  input  logic [2:0]       Sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Output,
  output logic             out_valid,
  output logic             Zero
);

  if (SHW != $clog2(WIDTH)) begin : g_bad_shw
    $error("alu_8op: SHW must equal clog2(WIDTH)");
  end

  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] result;

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .data   (A),
    .amt    (Shiftamt),
    .left   (Sel == ALU_SLL),
    .result (shift_res)
  );

  always_comb begin
    result = '0;
    case (Sel)
      ALU_ADD: result = A + B;
      ALU_SUB: result = A - B;
      ALU_OR:  result = A | B;
      ALU_XOR: result = A ^ B;
      ALU_AND: result = A & B;
      ALU_CMP: result = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL: result = shift_res;
      ALU_SRL: result = shift_res;
    endcase
  end

  // Zero is derived from the same value captured into Output, never from Output itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      Output    <= '0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Output <= result;
        Zero   <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_8op.sv
// Scoreboard bench for alu_8op: expected results queued at drive time, popped when out_valid is sampled.
module tb_alu_8op;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [5:0]   shiftamt;
  logic [2:0]   sel;
  logic         in_valid;
  logic [W-1:0] dut_out;
  logic         out_valid;
  logic         zero;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] sb[$];
  logic [W-1:0] m_out;
  logic         m_zero;

  localparam logic [W-1:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [W-1:0] PB = 64'hBBBB_BBBB_BBBB_BBBB;

  always #5 clk = ~clk;

  alu_8op #(.WIDTH(W), .SHW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a),
    .B         (b),
    .Shiftamt  (shiftamt),
    .Sel       (sel),
    .in_valid  (in_valid),
    .Output    (dut_out),
    .out_valid (out_valid),
    .Zero      (zero)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [5:0] s, input logic [2:0] op);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x | y;
      3'd3: return x ^ y;
      3'd4: return x & y;
      3'd5: return (x < y) ? 64'd1 : 64'd0;
      3'd6: return x << s;
      default: return x >> s;
    endcase
  endfunction

  // One clock: drive at negedge, queue the expectation, then check just after the rising edge.
  task automatic cycle(input string tag, input logic r, input logic v,
                       input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [5:0] s, input logic [2:0] op, input logic [W-1:0] exp);
    logic [W-1:0] e;
    @(negedge clk);
    rst = r; in_valid = v; a = xa; b = xb; shiftamt = s; sel = op;
    if (r) begin
      m_out  = '0;
      m_zero = 1'b1;
    end else if (v) begin
      sb.push_back(exp);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
      chk(tag, dut_out, e);
      chk({tag, "_zero"}, {63'd0, zero}, {63'd0, (e == '0)});
      m_out  = e;
      m_zero = (e == '0);
    end else begin
      chk({tag, "_vld"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_hold"}, dut_out, m_out);
      chk({tag, "_zero"}, {63'd0, zero}, {63'd0, m_zero});
    end
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] xa, xb;
    logic [5:0]   s;
    logic [2:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t dir[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [5:0]   rs;
    logic [2:0]   rop;
    logic         rv;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; shiftamt = '0; sel = '0;
    m_out = '0; m_zero = 1'b1;

    cycle("rst0", 1'b1, 1'b1, PA, PB, 6'd0, 3'd0, '0);
    cycle("rst1", 1'b1, 1'b0, PA, PB, 6'd0, 3'd0, '0);
    cycle("idle", 1'b0, 1'b0, PA, PB, 6'd0, 3'd0, '0);

    dir = '{
      '{"add",    PA, PB, 6'd0,  3'd0, 64'h6666_6666_6666_6665},
      '{"sub",    PA, PB, 6'd0,  3'd1, 64'hEEEE_EEEE_EEEE_EEEF},
      '{"or",     PA, PB, 6'd0,  3'd2, 64'hBBBB_BBBB_BBBB_BBBB},
      '{"xor",    PA, PB, 6'd0,  3'd3, 64'h1111_1111_1111_1111},
      '{"and",    PA, PB, 6'd0,  3'd4, 64'hAAAA_AAAA_AAAA_AAAA},
      '{"cmp",    PA, PB, 6'd0,  3'd5, 64'h0000_0000_0000_0001},
      '{"cmp_sw", PB, PA, 6'd0,  3'd5, 64'h0000_0000_0000_0000},
      '{"sll4",   PA, PB, 6'd4,  3'd6, 64'hAAAA_AAAA_AAAA_AAA0},
      '{"srl4",   PA, PB, 6'd4,  3'd7, 64'h0AAA_AAAA_AAAA_AAAA},
      '{"sll0",   PA, PB, 6'd0,  3'd6, 64'hAAAA_AAAA_AAAA_AAAA},
      '{"srl0",   PA, PB, 6'd0,  3'd7, 64'hAAAA_AAAA_AAAA_AAAA},
      '{"sll63",  PA, PB, 6'd63, 3'd6, 64'h0000_0000_0000_0000},
      '{"srl63",  ~64'd0, 64'd0, 6'd63, 3'd7, 64'h0000_0000_0000_0001},
      '{"addwrap", ~64'd0, 64'd1, 6'd0, 3'd0, 64'h0000_0000_0000_0000},
      '{"subwrap", 64'd0,  64'd1, 6'd0, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF}
    };
    foreach (dir[i]) cycle(dir[i].tag, 1'b0, 1'b1, dir[i].xa, dir[i].xb, dir[i].s, dir[i].op, dir[i].exp);
    cycle("gap", 1'b0, 1'b0, 64'd5, 64'd5, 6'd0, 3'd0, '0);

    // Back-to-back stream of all eight opcodes, Shiftamt=4 throughout.
    dir = '{
      '{"s_add", PA, PB, 6'd4, 3'd0, 64'h6666_6666_6666_6665},
      '{"s_sub", PA, PB, 6'd4, 3'd1, 64'hEEEE_EEEE_EEEE_EEEF},
      '{"s_or",  PA, PB, 6'd4, 3'd2, 64'hBBBB_BBBB_BBBB_BBBB},
      '{"s_xor", PA, PB, 6'd4, 3'd3, 64'h1111_1111_1111_1111},
      '{"s_and", PA, PB, 6'd4, 3'd4, 64'hAAAA_AAAA_AAAA_AAAA},
      '{"s_cmp", PA, PB, 6'd4, 3'd5, 64'h0000_0000_0000_0001},
      '{"s_sll", PA, PB, 6'd4, 3'd6, 64'hAAAA_AAAA_AAAA_AAA0},
      '{"s_srl", PA, PB, 6'd4, 3'd7, 64'h0AAA_AAAA_AAAA_AAAA}
    };
    foreach (dir[i]) cycle(dir[i].tag, 1'b0, 1'b1, dir[i].xa, dir[i].xb, dir[i].s, dir[i].op, dir[i].exp);
    cycle("s_hold0", 1'b0, 1'b0, 64'd0, 64'd0, 6'd0, 3'd0, '0);
    cycle("s_hold1", 1'b0, 1'b0, PB, PA, 6'd1, 3'd6, '0);

    // Reset while a result is presented and with a valid op on the same edge.
    cycle("pre_rst", 1'b0, 1'b1, PA, PB, 6'd0, 3'd3, 64'h1111_1111_1111_1111);
    cycle("rst_mid", 1'b1, 1'b1, PA, PB, 6'd0, 3'd2, '0);
    cycle("post_or", 1'b0, 1'b1, PA, PB, 6'd0, 3'd2, 64'hBBBB_BBBB_BBBB_BBBB);

    for (int i = 0; i < 40; i++) begin
      ra  = {$urandom, $urandom};
      rb  = (i % 5 == 0) ? ra : {$urandom, $urandom};
      rs  = 6'($urandom_range(0, 63));
      rop = 3'($urandom_range(0, 7));
      rv  = ($urandom_range(0, 3) != 0);
      cycle("rand", 1'b0, rv, ra, rb, rs, rop, model(ra, rb, rs, rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
